// File: rtl/avr_pkg.sv
// Shared types and constants for the AVR programming-mode blocks.
// Holds the readback FSM state encoding and the UART framing levels.
package avr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    SEND_LO = 3'd3,
    SEND_HI = 3'd4,
    SEND_CS = 3'd5,
    DONE    = 3'd6
  } rb_state_t;

  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP  = 1'b1;

endpackage

// File: rtl/prog_readback_if.sv
// Program-memory read port: the readback block drives address and strobe,
// and the memory returns data on the cycle after the strobe.
interface prog_readback_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data;

  modport master (output mem_addr, output mem_rd, input  mem_data);
  modport slave  (input  mem_addr, input  mem_rd, output mem_data);
endinterface

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter with a registered serial output.
// A load may arrive in the byte_done cycle, which gives back-to-back frames.
module uart_tx_byte
  import avr_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  output logic       tx,
  output logic       byte_done,
  output logic       tx_busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_idx_q, bit_idx_d;
  logic [9:0]        shift_q, shift_d;
  logic              active_q, active_d;
  logic              tx_q;
  logic              line_busy_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    active_d  = active_q;
    byte_done = active_q && (baud_q == BAUD_LAST) && (bit_idx_q == 4'd9);

    if (load) begin
      shift_d   = {UART_STOP, din, UART_START};
      baud_d    = '0;
      bit_idx_d = '0;
      active_d  = 1'b1;
    end else if (active_q) begin
      if (baud_q == BAUD_LAST) begin
        baud_d = '0;
        if (bit_idx_q == 4'd9) begin
          active_d = 1'b0;
          shift_d  = '1;
        end else begin
          bit_idx_d = bit_idx_q + 4'd1;
          shift_d   = {1'b1, shift_q[9:1]};
        end
      end else begin
        baud_d = baud_q + BAUD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop sees pre-edge values.
    if (rst) begin
      baud_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '1;
      active_q    <= 1'b0;
      tx_q        <= 1'b1;
      line_busy_q <= 1'b0;
    end else begin
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      active_q    <= active_d;
      tx_q        <= shift_q[0];
      line_busy_q <= active_q;
    end
  end

  // The output stage lags the shifter by one cycle; busy covers both.
  assign tx      = tx_q;
  assign tx_busy = active_q | line_busy_q;

endmodule

// File: rtl/prog_readback.sv
// Dumps a range of program-memory words over UART (lo byte, hi byte per word),
// followed by an 8-bit modulo-256 checksum of all data bytes.
module prog_readback
  import avr_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [15:0]        word_count,
  prog_readback_if.master    mem,
  output logic               uart_tx,
  output logic               busy,
  output logic               done
);

  rb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  logic [7:0]        word_hi_q, word_hi_d;
  logic [7:0]        csum_q, csum_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tx_load;
  logic [7:0]        tx_din;
  logic              tx_byte_done;
  logic              tx_busy;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (tx_load),
    .din      (tx_din),
    .tx       (uart_tx),
    .byte_done(tx_byte_done),
    .tx_busy  (tx_busy)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    word_hi_d  = word_hi_q;
    csum_d     = csum_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mem.mem_rd = 1'b0;
    tx_load    = 1'b0;
    tx_din     = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = start_addr;
          count_d = word_count;
          csum_d  = '0;
          busy_d  = 1'b1;
          state_d = (word_count == 16'd0) ? SEND_CS : FETCH;
        end
      end
      FETCH: begin
        mem.mem_rd = 1'b1;
        state_d    = WAIT;
      end
      // The low byte goes straight from the memory bus so the frame starts
      // one cycle after WAIT on the line; only the high byte needs holding.
      WAIT: begin
        word_hi_d = mem.mem_data[15:8];
        tx_load   = 1'b1;
        tx_din    = mem.mem_data[7:0];
        csum_d    = csum_q + mem.mem_data[7:0];
        state_d   = SEND_LO;
      end
      SEND_LO: begin
        if (tx_byte_done) begin
          tx_load = 1'b1;
          tx_din  = word_hi_q;
          csum_d  = csum_q + word_hi_q;
          state_d = SEND_HI;
        end
      end
      SEND_HI: begin
        if (tx_byte_done) begin
          count_d = count_q - 16'd1;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = (count_q == 16'd1) ? SEND_CS : FETCH;
        end
      end
      // The checksum waits for the line to go fully idle before loading.
      SEND_CS: begin
        if (tx_byte_done) begin
          state_d = DONE;
        end else if (!tx_busy) begin
          tx_load = 1'b1;
          tx_din  = csum_q;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      word_hi_q <= '0;
      csum_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      word_hi_q <= word_hi_d;
      csum_q    <= csum_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mem.mem_addr = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_prog_readback.sv
// Directed bench for prog_readback: memory model, mid-bit UART monitor and
// a byte scoreboard filled from a reference model when each dump is started.
module tb_prog_readback;
  import avr_pkg::*;

  localparam int C    = 4;
  localparam int HALF = C / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] word_count = '0;
  logic        uart_tx, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int fall_cyc = -1;
  int last_done_cyc = 0;
  int done_pulses = 0;
  int mem_rd_cnt = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] addr_log[$];

  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = '0;

  prog_readback_if #(.ADDR_W(16), .DATA_W(16)) mem_if ();

  prog_readback #(.CLKS_PER_BIT(C), .ADDR_W(16), .DATA_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .word_count(word_count),
    .mem       (mem_if),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Memory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_if.mem_rd === 1'b1) mem_if.mem_data <= mem_if.mem_addr ^ 16'h5A00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mem_if.mem_rd === 1'b1) begin
      mem_rd_cnt++;
      addr_log.push_back(mem_if.mem_addr);
    end
    if (!rst && done === 1'b1) begin
      done_pulses++;
      last_done_cyc = cyc;
    end
  end

  // UART monitor: detects the start edge, then samples each bit mid-way
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_byte   = '0;
        if (fall_cyc < 0) fall_cyc = cyc;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % C == HALF) begin
        if (mon_cnt / C == 0) begin
          check("rx_start_bit", uart_tx, 1'b0);
        end else if (mon_cnt / C <= 8) begin
          mon_byte[mon_cnt / C - 1] = uart_tx;
        end else begin
          check("rx_stop_bit", uart_tx, 1'b1);
          check("rx_byte_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("rx_byte", mon_byte, exp_q.pop_front());
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic push_dump(input logic [15:0] addr, input int count);
    logic [7:0]  sum = '0;
    logic [15:0] a, w;
    for (int i = 0; i < count; i++) begin
      a = addr + 16'(i);
      w = a ^ 16'h5A00;
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
      sum = sum + w[7:0] + w[15:8];
    end
    exp_q.push_back(sum);
  endtask

  task automatic pulse_start(input logic [15:0] addr, input logic [15:0] count);
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = addr;
    word_count = count;
    start_cyc  = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    int lows = 0;
    bit seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
      else if (busy !== 1'b1) lows++;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_busy_high"}, lows, 0);
  endtask

  initial begin
    int d0, r0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_mem_rd", mem_if.mem_rd, 1'b0);
    check("rst_mem_addr", mem_if.mem_addr, 16'h0000);

    // T1 with T4: a second start 5 cycles in must be ignored
    d0 = done_pulses;
    push_dump(16'h0010, 2);
    pulse_start(16'h0010, 16'd2);
    repeat (3) @(posedge clk);
    pulse_start(16'h0100, 16'd3);
    wait_done("t1", 2000);
    repeat (20) @(negedge clk);
    check("t1_all_bytes", exp_q.size(), 0);
    check("t1_one_done", done_pulses - d0, 1);

    // T2: empty range sends only the zero checksum
    d0 = done_pulses;
    r0 = mem_rd_cnt;
    push_dump(16'h1234, 0);
    pulse_start(16'h1234, 16'd0);
    wait_done("t2", 500);
    repeat (5) @(negedge clk);
    check("t2_all_bytes", exp_q.size(), 0);
    check("t2_one_done", done_pulses - d0, 1);
    check("t2_no_mem_rd", mem_rd_cnt - r0, 0);

    // T3: address wraps from FFFF to 0000
    addr_log.delete();
    push_dump(16'hFFFF, 2);
    pulse_start(16'hFFFF, 16'd2);
    wait_done("t3", 2000);
    repeat (5) @(negedge clk);
    check("t3_all_bytes", exp_q.size(), 0);
    check("t3_rd_count", addr_log.size(), 2);
    if (addr_log.size() >= 2) begin
      check("t3_addr0", addr_log[0], 16'hFFFF);
      check("t3_addr1", addr_log[1], 16'h0000);
    end

    // T5: reset mid-bit of the second byte, then a clean dump
    push_dump(16'h0020, 2);
    pulse_start(16'h0020, 16'd2);
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    check("t5_uart_tx_idle", uart_tx, 1'b1);
    check("t5_busy_low", busy, 1'b0);
    check("t5_done_low", done, 1'b0);
    repeat (5) @(posedge clk);
    d0 = done_pulses;
    push_dump(16'h0020, 2);
    pulse_start(16'h0020, 16'd2);
    wait_done("t5", 2000);
    repeat (5) @(negedge clk);
    check("t5_all_bytes", exp_q.size(), 0);
    check("t5_one_done", done_pulses - d0, 1);

    // T6: latency to first start bit and to done for a single word
    push_dump(16'h0042, 1);
    fall_cyc = -1;
    pulse_start(16'h0042, 16'd1);
    wait_done("t6", 1000);
    repeat (5) @(negedge clk);
    check("t6_all_bytes", exp_q.size(), 0);
    check("t6_start_to_fall", fall_cyc - start_cyc, 3);
    check("t6_fall_to_done", last_done_cyc - fall_cyc, 30 * C + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
